// File: rtl/vec_uart_streamer.sv
// Drains a block of vector-memory words onto an 8N1 UART line, lowest byte of each word first.
// Optional build macro STREAM_CHECKSUM_EN appends a modulo-256 byte-sum trailer frame.
module vec_uart_streamer #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned DATA_W   = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);
    localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StSend, StDone} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     byte_idx_q, byte_idx_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [15:0]       baud_q, baud_d;

    logic bit_end, frame_end, last_byte, last_word, data_frame;
    logic [7:0] cur_byte;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign frame_end = bit_end && (bit_idx_q == 4'd9);
    assign last_byte = (byte_idx_q == BYTE_LAST);
    assign last_word = ((idx_q + ADDR_W'(1)) == count_q);
    assign cur_byte  = shreg_q[7:0];

`ifdef STREAM_CHECKSUM_EN
    logic       trailer_q, trailer_d;
    logic [7:0] sum_q, sum_d;
    assign data_frame = !trailer_q;
`else
    assign data_frame = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (word_count == '0) ? StDone : StFetch;
                end
            end
            StFetch: state_d = StWait;
            StWait:  state_d = StSend;
            StSend: begin
                if (frame_end) begin
`ifdef STREAM_CHECKSUM_EN
                    if (trailer_q) begin
                        state_d = StDone;
                    end else if (last_byte && !last_word) begin
                        state_d = StFetch;
                    end
`else
                    if (last_byte) begin
                        state_d = last_word ? StDone : StFetch;
                    end
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        base_d     = base_q;
        count_d    = count_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
`ifdef STREAM_CHECKSUM_EN
        trailer_d  = trailer_q;
        sum_d      = sum_q;
`endif
        case (state_q)
            StIdle: begin
                if (start && (word_count != '0)) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    idx_d   = '0;
                    addr_d  = base_addr;
`ifdef STREAM_CHECKSUM_EN
                    trailer_d = 1'b0;
                    sum_d     = '0;
`endif
                end
            end
            StWait: begin
                shreg_d    = mem_rdata;
                byte_idx_d = '0;
                bit_idx_d  = '0;
                baud_d     = '0;
            end
            StSend: begin
                if (!bit_end) begin
                    baud_d = baud_q + 16'd1;
                end else begin
                    baud_d = '0;
                    if (bit_idx_q != 4'd9) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else begin
                        bit_idx_d = '0;
                        if (data_frame) begin
                            shreg_d    = shreg_q >> 8;
                            byte_idx_d = last_byte ? '0 : byte_idx_q + BW'(1);
                            if (last_byte) begin
                                idx_d = idx_q + ADDR_W'(1);
                                // Keep mem_addr stable after the final word.
                                if (!last_word) begin
                                    addr_d = base_q + idx_q + ADDR_W'(1);
                                end
                            end
`ifdef STREAM_CHECKSUM_EN
                            sum_d = sum_q + cur_byte;
                            if (last_byte && last_word) begin
                                trailer_d     = 1'b1;
                                shreg_d[7:0]  = sum_q + cur_byte;
                            end
`endif
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
`ifdef STREAM_CHECKSUM_EN
            trailer_q  <= 1'b0;
            sum_q      <= '0;
`endif
        end else begin
            base_q     <= base_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
`ifdef STREAM_CHECKSUM_EN
            trailer_q  <= trailer_d;
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        tx        = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = addr_q;
        unique case (state_q)
            StIdle: ;
            StFetch: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
            end
            StWait: busy = 1'b1;
            StSend: begin
                busy = 1'b1;
                if (bit_idx_q == 4'd0) begin
                    tx = 1'b0;
                end else if (bit_idx_q != 4'd9) begin
                    tx = cur_byte[3'(bit_idx_q - 4'd1)];
                end
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule
